// File: rtl/regfile_pkg.sv
// regfile_pkg: constants shared by the 4-entry register file, its write-select
// decoder and the write-port arbiter, plus the arbiter lock-FSM state type.
package regfile_pkg;
   localparam int REG_SEL_W = 2;
   localparam int NUM_REGS  = 4;

   typedef enum logic {
      ARB_S    = 1'b0,
      LOCKED_S = 1'b1
   } arb_state_e;
endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rr_pick: combinational N-wide round-robin priority picker.
// Ports:
//   i_req  - request vector, bit i = requester i
//   i_ptr  - highest-priority requester index
//   i_mask - eligibility mask ANDed with i_req
//   o_gnt  - one-hot grant (zero when nothing eligible)
//   o_idx  - index of the granted requester (valid when o_any)
//   o_any  - at least one eligible request
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   input  logic [N-1:0]  i_mask,
   output logic [N-1:0]  o_gnt,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);
   logic [N-1:0] w_eff;
   logic [N-1:0] w_rot;
   int           w_first;
   int           w_sum;

   always_comb begin
      w_eff = i_req & i_mask;
      // Rotate so that requester i_ptr lands at bit 0; the double-width copy
      // supplies the wrapped-around requesters in the upper positions.
      w_rot = N'({w_eff, w_eff} >> i_ptr);
      o_any = |w_eff;
      w_first = 0;
      for (int k = N - 1; k >= 0; k--)
         if (w_rot[k]) w_first = k;
      // Undo the rotation, wrapping modulo N (N need not be a power of two).
      w_sum = int'(i_ptr) + w_first;
      if (w_sum >= N) w_sum = w_sum - N;
      o_idx = '0;
      o_gnt = '0;
      if (o_any) begin
         o_idx = PW'(w_sum);
         o_gnt = N'(1) << w_sum;
      end
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the single write port of
// the register file among N requesters. One grant per cycle; the granted
// request is registered onto rf_en/rf_in_sel/rf_in one cycle later.
// Optional feature macro: REGFILE_ARB_LOCK_EN (adds lock port + ARB/LOCKED FSM
// letting a granted requester hold the port for consecutive writes).
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   req        - per-requester write request
//   req_sel    - per-requester destination select, 2 bits each
//   req_data   - per-requester write data, W bits each
//   lock       - (REGFILE_ARB_LOCK_EN only) per-requester lock request
//   gnt        - combinational one-hot grant
//   rf_en, rf_in_sel, rf_in - registered register-file write port
//   busy       - registered: any request was seen last cycle
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int W = 32,
   parameter int N = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           req,
   input  logic [REG_SEL_W*N-1:0] req_sel,
   input  logic [W*N-1:0]         req_data,
`ifdef REGFILE_ARB_LOCK_EN
   input  logic [N-1:0]           lock,
`endif
   output logic [N-1:0]           gnt,
   output logic                   rf_en,
   output logic [REG_SEL_W-1:0]   rf_in_sel,
   output logic [W-1:0]           rf_in,
   output logic                   busy
);
   localparam int PW = $clog2(N);

   logic [PW-1:0]        r_ptr;
   logic [N-1:0]         w_mask;
   logic [N-1:0]         w_gnt;
   logic [PW-1:0]        w_idx;
   logic                 w_any;
   logic [REG_SEL_W-1:0] w_sel;
   logic [W-1:0]         w_data;

   // Pointer increment that wraps at N-1, so values >= N are never produced.
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
      return (int'(v) == N - 1) ? '0 : v + 1'b1;
   endfunction

`ifdef REGFILE_ARB_LOCK_EN
   arb_state_e    r_state;
   logic [PW-1:0] r_owner;

   // While locked only the owner is eligible.
   always_comb begin
      w_mask = '1;
      if (r_state == LOCKED_S) w_mask = N'(1) << r_owner;
   end
`else
   assign w_mask = '1;
`endif

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .i_req  (req),
      .i_ptr  (r_ptr),
      .i_mask (w_mask),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   assign gnt    = reset ? '0 : w_gnt;
   assign w_sel  = req_sel[w_idx*REG_SEL_W +: REG_SEL_W];
   assign w_data = req_data[w_idx*W +: W];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr     <= '0;
         rf_en     <= 1'b0;
         rf_in_sel <= '0;
         rf_in     <= '0;
         busy      <= 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
         r_state   <= ARB_S;
         r_owner   <= '0;
`endif
      end else begin
         busy  <= |req;
         rf_en <= w_any;
         // Select/data hold their last value on idle cycles.
         if (w_any) begin
            rf_in_sel <= w_sel;
            rf_in     <= w_data;
         end
`ifdef REGFILE_ARB_LOCK_EN
         case (r_state)
            ARB_S: begin
               if (w_any) begin
                  r_ptr <= wrap_inc(w_idx);
                  if (lock[w_idx]) begin
                     r_state <= LOCKED_S;
                     r_owner <= w_idx;
                  end
               end
            end
            LOCKED_S: begin
               // Pointer is frozen while locked; release hands priority on.
               if (!req[r_owner] || !lock[r_owner]) begin
                  r_state <= ARB_S;
                  r_ptr   <= wrap_inc(r_owner);
               end
            end
            default: r_state <= ARB_S;
         endcase
`else
         if (w_any) r_ptr <= wrap_inc(w_idx);
`endif
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-free behavioural model of the
// round-robin rules and a small register file fed by the DUT write port.
module tb_regfile_write_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [2*N-1:0] req_sel;
   logic [W*N-1:0] req_data;
   logic [N-1:0]   lock_v;
   logic [N-1:0]   gnt;
   logic           rf_en;
   logic [1:0]     rf_in_sel;
   logic [W-1:0]   rf_in;
   logic           busy;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.W(W), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_sel   (req_sel),
      .req_data  (req_data),
`ifdef REGFILE_ARB_LOCK_EN
      .lock      (lock_v),
`endif
      .gnt       (gnt),
      .rf_en     (rf_en),
      .rf_in_sel (rf_in_sel),
      .rf_in     (rf_in),
      .busy      (busy)
   );

   // Register file driven by the DUT write port.
   logic [W-1:0] tb_rf [4];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) tb_rf[i] <= '0;
      end else if (rf_en) begin
         tb_rf[rf_in_sel] <= rf_in;
      end
   end

   // Reference model state.
   int           m_ptr;
   bit           m_locked;
   int           m_owner;
   logic         m_en;
   logic [1:0]   m_sel;
   logic [W-1:0] m_in;
   logic         m_busy;
   logic [W-1:0] mrf [4];

   int           n_assert = 0;
   int           n_fail   = 0;
   logic [N-1:0] last_gnt;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick();
      int i;
      if (reset) return -1;
      if (m_locked) return req[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         i = (m_ptr + k) % N;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   task automatic put(input int i, input logic [1:0] s, input logic [W-1:0] d);
      req_sel[2*i +: 2]  = s;
      req_data[W*i +: W] = d;
   endtask

   // One clock cycle: check grant mid-cycle, step the model at the edge,
   // then check the registered port and register-file contents.
   task automatic cyc();
      int g;
      #2;
      g = model_pick();
      last_gnt = gnt;
      chk("gnt", W'(gnt), (g < 0) ? W'(0) : (W'(1) << g));
      @(posedge clk);
      if (reset) begin
         m_ptr = 0; m_locked = 0; m_owner = 0;
         m_en = 0; m_sel = 0; m_in = 0; m_busy = 0;
         for (int i = 0; i < 4; i++) mrf[i] = '0;
      end else begin
         if (m_en) mrf[m_sel] = m_in;
         m_busy = |req;
         m_en   = (g >= 0);
         if (g >= 0) begin
            m_sel = req_sel[2*g +: 2];
            m_in  = req_data[W*g +: W];
         end
         if (m_locked) begin
            if (!req[m_owner] || !lock_v[m_owner]) begin
               m_locked = 0;
               m_ptr    = (m_owner + 1) % N;
            end
         end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (lock_v[g]) begin
               m_locked = 1;
               m_owner  = g;
            end
         end
      end
      #1;
      chk("rf_en", W'(rf_en), W'(m_en));
      chk("rf_in_sel", W'(rf_in_sel), W'(m_sel));
      chk("rf_in", rf_in, m_in);
      chk("busy", W'(busy), W'(m_busy));
      for (int i = 0; i < 4; i++) chk($sformatf("rf%0d", i), tb_rf[i], mrf[i]);
   endtask

   initial begin
      reset = 1'b1; req = '0; req_sel = '0; req_data = '0; lock_v = '0;
      m_owner = 0;

      // Reset then single request from requester 2.
      cyc(); cyc();
      chk("rst_rf_en", W'(rf_en), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      reset = 1'b0;
      req = 4'b0100; put(2, 2'd3, 32'hDEADBEEF);
      cyc();
      chk("t1_gnt", W'(last_gnt), 32'h4);
      chk("t1_en", W'(rf_en), 32'h1);
      chk("t1_sel", W'(rf_in_sel), 32'h3);
      chk("t1_data", rf_in, 32'hDEADBEEF);
      req = '0;
      cyc();
      chk("t1_rf3", tb_rf[3], 32'hDEADBEEF);

      // Full contention from ptr=0.
      reset = 1'b1; cyc(); reset = 1'b0;
      for (int i = 0; i < N; i++) put(i, 2'(i), 32'h100 + 32'(i));
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("t2_gnt", W'(last_gnt), W'(1) << (k % 4));
         chk("t2_en", W'(rf_en), 32'h1);
      end
      req = '0; cyc();
      chk("t2_en_off", W'(rf_en), 32'h0);

      // Same destination: last granted value wins.
      reset = 1'b1; cyc(); reset = 1'b0;
      put(0, 2'd1, 32'h1); put(1, 2'd1, 32'h2);
      req = 4'b0011; cyc();
      chk("t3_first", W'(last_gnt), 32'h1);
      req = 4'b0010; cyc();
      chk("t3_second", W'(last_gnt), 32'h2);
      req = '0; cyc(); cyc();
      chk("t3_rf1", tb_rf[1], 32'h2);

      // Reset mid-burst drops the pending write.
      reset = 1'b1; cyc(); reset = 1'b0;
      put(0, 2'd0, 32'hAAAA0000); put(1, 2'd2, 32'hBBBB1111);
      req = 4'b0011; cyc(); cyc();
      reset = 1'b1; cyc();
      chk("t4_gnt", W'(last_gnt), 32'h0);
      chk("t4_en", W'(rf_en), 32'h0);
      reset = 1'b0; cyc();
      chk("t4_restart", W'(last_gnt), 32'h1);

      // Idle hold after a write.
      req = 4'b0100; put(2, 2'd2, 32'hA5A5A5A5); cyc();
      req = '0;
      for (int k = 0; k < 5; k++) cyc();
      chk("t5_en", W'(rf_en), 32'h0);
      chk("t5_sel", W'(rf_in_sel), 32'h2);
      chk("t5_data", rf_in, 32'hA5A5A5A5);
      chk("t5_busy", W'(busy), 32'h0);

`ifdef REGFILE_ARB_LOCK_EN
      // Lock: requester 1 holds the port, then releases to requester 2.
      reset = 1'b1; cyc(); reset = 1'b0;
      req = 4'b0001; cyc();
      req = 4'b0111; lock_v = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t6_lock", W'(last_gnt), 32'h2);
      end
      req = 4'b0101; lock_v = '0; cyc();
      chk("t6_release", W'(last_gnt), 32'h0);
      cyc();
      chk("t6_next2", W'(last_gnt), 32'h4);
      req = 4'b0001; cyc();
      chk("t6_next0", W'(last_gnt), 32'h1);
      req = '0; cyc();
`endif

      // Random traffic; requesters hold their write until granted.
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < N; i++) begin
            if (!req[i] || last_gnt[i]) begin
               req[i] = ($urandom_range(0, 2) != 0);
               put(i, 2'($urandom_range(0, 3)), $urandom);
            end
         end
`ifdef REGFILE_ARB_LOCK_EN
         lock_v = N'($urandom) & N'($urandom);
`endif
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
